fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch front end for the mARC 16-bit core. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, and holds the fetched word in an instruction register. That register drives the `instruction` input of the control unit, and the block accepts branch/jmpl/call redirects back from the control path. It is the producer side of the control unit's instruction interface.

## Interface
- `ADDR_W`, 16, instruction memory word-address width.
- `RESET_PC`, 16'h0000, first fetch address after reset.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `mem_req`  out  1  read request to instruction memory.
- `mem_addr`  out  ADDR_W  word address of the request.
- `mem_ack`  in  1  memory response strobe; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  16  instruction word from memory.
- `instruction`  out  16  current instruction, to the control unit.
- `instr_valid`  out  1  `instruction` holds an unconsumed word.
- `instr_next`  in  1  control unit retires the current instruction.
- `pc`  out  ADDR_W  address of `instruction`, used as the call link value.
- `redirect`  in  1  load a new PC; qualified by `redirect_pc`.
- `redirect_pc`  in  ADDR_W  branch, jmpl or call target.

## Operation
- All outputs are registered.
- Reset values: `mem_req`=0, `mem_addr`=`RESET_PC`, `instruction`=16'h0000, `instr_valid`=0, `pc`=`RESET_PC`. The squash flag and prefetch buffer are cleared.
- States:
  - RST: held while `reset`=0.
  - REQ: `mem_req`=1, waiting for `mem_ack`.
  - HOLD: `instr_valid`=1, waiting for `instr_next` or `redirect`.
- Transitions:
  - RST -> REQ on the first edge with `reset`=1. At that edge `mem_addr`=`pc`.
  - REQ -> HOLD on the edge where `mem_ack`=1: `instruction`<=`mem_rdata`, `instr_valid`<=1, `mem_req`<=0.
  - HOLD -> REQ on `instr_next`=1: `instr_valid`<=0, `pc`<=`pc`+1, `mem_addr`<=`pc`+1, `mem_req`<=1.
- Handshake:
  - `mem_req` and `mem_addr` stay stable until `mem_ack` is sampled high.
  - A request is never withdrawn.
  - `mem_ack` while `mem_req`=0 is ignored.
- `instr_next` is ignored while `instr_valid`=0.
- PC arithmetic is modulo 2^ADDR_W; 16'hFFFF+1 wraps to 16'h0000.
- Redirect has priority over `instr_next` and over a completing ack.
  - At a `redirect` edge: `pc`<=`redirect_pc` and `instr_valid`<=0.
  - With no request outstanding, `mem_req`<=1 and `mem_addr`<=`redirect_pc` in the same edge.
  - With a request outstanding, the squash flag is set. The outstanding ack is consumed and its data discarded. The next edge then issues a request to `redirect_pc`.
  - A second redirect while squashed only updates `pc`.
- Reset mid-handshake drops `mem_req` immediately. The bench memory must also be reset.

## Timing
- Non-prefetch fetch latency: ack at edge N gives `instr_valid`=1 after edge N.
- Retire-to-valid: `instr_next` at edge N raises `mem_req` after edge N. With a 1-cycle memory, `instr_valid` returns after edge N+2. This is a 2-cycle bubble.
- Redirect-to-request: 1 edge when idle. When squashed, ack edge +1.
- First request is visible one cycle after reset deassertion.

## Configuration
- `FETCH_PREFETCH_EN` defined: one-entry prefetch buffer (`pbuf`, `pbuf_valid`).
  - While in HOLD with no request outstanding and the buffer empty, the block issues a read of `pc`+1 and stores the response in `pbuf`.
  - On `instr_next` with `pbuf_valid`=1: `instruction`<=`pbuf`, `pc`<=`pc`+1, `instr_valid` stays 1 (zero bubble), and the next prefetch is issued.
  - `instr_next` and the prefetch ack on the same edge: `mem_rdata` goes directly to `instruction` and `instr_valid` stays 1.
  - Redirect clears `pbuf_valid` and squashes any outstanding prefetch.
- Undefined: no buffer. At most one request is in flight, and it is issued only when `instr_valid`=0. Behaviour is exactly as in Operation.

## Test plan
- Reset release with `RESET_PC`=0, 1-cycle memory returning 16'h2322: `mem_req`=1, `mem_addr`=0 on the first cycle. Then `instruction`=16'h2322, `instr_valid`=1, `pc`=0.
- Retire sequence 16'h2322, 16'h3701, 16'h3F11 at addresses 0..2 with `instr_next` pulses: `pc` steps 0,1,2 and `instruction` matches in order. Non-prefetch shows a 2-cycle bubble between words; prefetch shows none.
- `redirect`=1, `redirect_pc`=16'h0040 while in HOLD at `pc`=2: `instr_valid`=0 next cycle, then `mem_addr`=16'h0040. The word at 0x40 (16'h4807) is presented with `pc`=16'h0040.
- Redirect to 16'h0080 while a 3-cycle-latency request to address 3 is outstanding: `mem_req` holds until the ack, the returned word is discarded and `instr_valid` stays 0, then a request to 16'h0080 is issued.
- PC wrap: `redirect_pc`=16'hFFFF, then `instr_next`: the next `mem_addr` is 16'h0000.
- `reset`=0 asserted during an outstanding request: all outputs return to their reset values on the next edge, and fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: mARC instruction fetch front end (PC, imem req/ack, instruction register).
// Optional one-entry prefetch buffer enabled by defining FETCH_PREFETCH_EN.
module fetch_unit #(
    parameter int ADDR_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       instruction,
    output logic              instr_valid,
    input  logic              instr_next,
    output logic [ADDR_W-1:0] pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);
    typedef enum logic [1:0] {RST, REQ, HOLD} state_e;

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic              squash_q, squash_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc_inc;
    logic              ack;

    assign ack    = req_q && mem_ack;
    assign pc_inc = pc_q + ADDR_W'(1);

`ifdef FETCH_PREFETCH_EN
    logic [15:0]       pbuf_q, pbuf_d;
    logic              pbuf_valid_q, pbuf_valid_d;
    logic [ADDR_W-1:0] pc_inc2;
    assign pc_inc2 = pc_q + ADDR_W'(2);
`endif

    // State and output registers; reset drops any request in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= RST;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            squash_q <= 1'b0;
            addr_q   <= RESET_PC;
            pc_q     <= RESET_PC;
            instr_q  <= 16'h0000;
`ifdef FETCH_PREFETCH_EN
            pbuf_q       <= 16'h0000;
            pbuf_valid_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
            squash_q <= squash_d;
            addr_q   <= addr_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
`ifdef FETCH_PREFETCH_EN
            pbuf_q       <= pbuf_d;
            pbuf_valid_q <= pbuf_valid_d;
`endif
        end
    end

    // Next state: redirect beats retire and ack; a squashed ack is swallowed before refetching.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        valid_d  = valid_q;
        squash_d = squash_q;
        addr_d   = addr_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
`ifdef FETCH_PREFETCH_EN
        pbuf_d       = pbuf_q;
        pbuf_valid_d = pbuf_valid_q;
`endif
        if (state_q == RST) begin
            state_d = REQ;
            req_d   = 1'b1;
            addr_d  = pc_q;
        end else if (redirect) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            state_d = REQ;
`ifdef FETCH_PREFETCH_EN
            pbuf_valid_d = 1'b0;
`endif
            if (!req_q) begin
                req_d  = 1'b1;
                addr_d = redirect_pc;
            end else if (mem_ack) begin
                req_d    = 1'b0;
                squash_d = 1'b0;
            end else begin
                squash_d = 1'b1;
            end
        end else if (squash_q) begin
            if (ack) begin
                req_d    = 1'b0;
                squash_d = 1'b0;
            end
        end else if (state_q == REQ) begin
            if (!req_q) begin
                req_d  = 1'b1;
                addr_d = pc_q;
            end else if (mem_ack) begin
                instr_d = mem_rdata;
                valid_d = 1'b1;
                req_d   = 1'b0;
                state_d = HOLD;
            end
        end else begin
`ifdef FETCH_PREFETCH_EN
            if (instr_next) begin
                pc_d = pc_inc;
                if (pbuf_valid_q || ack) begin
                    instr_d      = pbuf_valid_q ? pbuf_q : mem_rdata;
                    pbuf_valid_d = 1'b0;
                    req_d        = 1'b1;
                    addr_d       = pc_inc2;
                end else begin
                    valid_d = 1'b0;
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = pc_inc;
                end
            end else if (ack) begin
                pbuf_d       = mem_rdata;
                pbuf_valid_d = 1'b1;
                req_d        = 1'b0;
            end else if (!req_q && !pbuf_valid_q) begin
                req_d  = 1'b1;
                addr_d = pc_inc;
            end
`else
            if (instr_next) begin
                valid_d = 1'b0;
                pc_d    = pc_inc;
                addr_d  = pc_inc;
                req_d   = 1'b1;
                state_d = REQ;
            end
`endif
        end
    end

    assign mem_req     = req_q;
    assign mem_addr    = addr_q;
    assign instruction = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized check of fetch_unit against a transaction-level fetch model.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] instruction;
    logic        instr_valid;
    logic        instr_next;
    logic [15:0] pc;
    logic        redirect;
    logic [15:0] redirect_pc;

    localparam logic [15:0] RESET_PC = 16'h0000;

    fetch_unit #(.ADDR_W(16), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instruction(instruction),
        .instr_valid(instr_valid), .instr_next(instr_next), .pc(pc),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          errors = 0;
    logic [15:0] exp_pc = RESET_PC;
    bit          dirty = 0;
    bit          in_rst = 1;
    int          idle = 0;
    int          wait_cnt = 0;
    int          lat = 1;
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          k;

    function automatic logic [15:0] word(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h2322;
            16'h0001: return 16'h3701;
            16'h0002: return 16'h3F11;
            16'h0040: return 16'h4807;
            default:  return (a * 16'h9E37) ^ 16'h5A5A;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: observe the edge, check it against the fetch rules, then drive memory.
    task automatic step();
        logic        p_req, p_valid, p_ack, p_next, p_redir, p_rst, ack_edge, dirty_b, exp_valid;
        logic [15:0] p_addr, p_rpc;
        p_req = mem_req; p_addr = mem_addr; p_valid = instr_valid; p_ack = mem_ack;
        p_next = instr_next; p_redir = redirect; p_rpc = redirect_pc; p_rst = reset;
        @(posedge clk);
        @(negedge clk);
        if (!p_rst) begin
            chk("rst_req", mem_req, 0);
            chk("rst_addr", mem_addr, RESET_PC);
            chk("rst_instr", instruction, 0);
            chk("rst_valid", instr_valid, 0);
            chk("rst_pc", pc, RESET_PC);
            exp_pc = RESET_PC; dirty = 0; in_rst = 1; idle = 0; wait_cnt = 0;
        end else if (in_rst) begin
            in_rst = 0;
            chk("start_req", mem_req, 1);
            chk("start_addr", mem_addr, exp_pc);
            chk("start_valid", instr_valid, 0);
            chk("start_pc", pc, exp_pc);
        end else begin
            ack_edge = p_req && p_ack;
            dirty_b = dirty;
            if (ack_edge) dirty = 0;
            if (p_redir) begin
                exp_pc = p_rpc;
                if (p_req && !ack_edge) dirty = 1;
            end else if (p_valid && p_next) begin
                exp_pc = exp_pc + 16'h1;
            end
            exp_valid = p_redir ? 1'b0 : p_valid ? !p_next : (ack_edge && !dirty_b);
            chk("valid", instr_valid, exp_valid);
            chk("pc", pc, exp_pc);
            if (exp_valid) chk("instr", instruction, word(exp_pc));
            if (p_req && !ack_edge) begin
                chk("req_hold", mem_req, 1);
                chk("addr_hold", mem_addr, p_addr);
            end else if (ack_edge) begin
                chk("req_drop", mem_req, 0);
            end else if (p_redir || (p_valid && p_next)) begin
                chk("req_issue", mem_req, 1);
            end
            if (!p_req && mem_req) chk("req_addr", mem_addr, exp_pc);
            idle = (!mem_req && !instr_valid) ? idle + 1 : 0;
            chk("no_stall", idle < 2, 1);
        end
        if (!reset) begin
            mem_ack = 0;
            wait_cnt = 0;
        end else if (mem_req) begin
            if (wait_cnt == lat) begin
                mem_ack = 1;
                mem_rdata = word(mem_addr);
                wait_cnt = 0;
                lat = $urandom_range(lat_hi, lat_lo);
            end else begin
                mem_ack = 0;
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
            mem_ack = ($urandom_range(7, 0) == 0);
            mem_rdata = 16'($urandom);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!instr_valid && n < 20) begin
            step();
            n++;
        end
        chk("valid_timeout", instr_valid, 1);
    endtask

    initial begin
        reset = 0; mem_ack = 0; mem_rdata = 0; instr_next = 0; redirect = 0; redirect_pc = 0;
        repeat (3) step();
        reset = 1;
        step();
        chk("tp1_req", mem_req, 1);
        chk("tp1_addr", mem_addr, 16'h0000);
        wait_valid(k);
        chk("tp1_lat", k, 2);
        chk("tp1_instr", instruction, 16'h2322);
        chk("tp1_pc", pc, 16'h0000);
        instr_next = 1; step(); instr_next = 0;
        chk("tp2_req", mem_req, 1);
        chk("tp2_addr", mem_addr, 16'h0001);
        wait_valid(k);
        chk("tp2_bubble", k, 2);
        chk("tp2_instr1", instruction, 16'h3701);
        chk("tp2_pc1", pc, 16'h0001);
        instr_next = 1; step(); instr_next = 0;
        wait_valid(k);
        chk("tp2_instr2", instruction, 16'h3F11);
        chk("tp2_pc2", pc, 16'h0002);
        redirect = 1; redirect_pc = 16'h0040; step(); redirect = 0;
        chk("tp3_valid", instr_valid, 0);
        chk("tp3_addr", mem_addr, 16'h0040);
        wait_valid(k);
        chk("tp3_instr", instruction, 16'h4807);
        chk("tp3_pc", pc, 16'h0040);
        redirect = 1; redirect_pc = 16'h0002; step(); redirect = 0;
        wait_valid(k);
        lat = 3; lat_lo = 3; lat_hi = 3;
        instr_next = 1; step(); instr_next = 0;
        step();
        redirect = 1; redirect_pc = 16'h0080; step(); redirect = 0;
        chk("tp4_req", mem_req, 1);
        chk("tp4_addr", mem_addr, 16'h0003);
        chk("tp4_pc", pc, 16'h0080);
        k = 0;
        while (mem_req && k < 10) begin
            step();
            chk("tp4_discard", instr_valid, 0);
            k++;
        end
        lat = 1; lat_lo = 1; lat_hi = 1;
        step();
        chk("tp4_reissue", mem_req, 1);
        chk("tp4_addr80", mem_addr, 16'h0080);
        wait_valid(k);
        chk("tp4_instr", instruction, 16'h41DA);
        redirect = 1; redirect_pc = 16'hFFFF; step(); redirect = 0;
        wait_valid(k);
        chk("tp5_pc", pc, 16'hFFFF);
        instr_next = 1; step(); instr_next = 0;
        chk("tp5_addr", mem_addr, 16'h0000);
        chk("tp5_pcwrap", pc, 16'h0000);
        reset = 0; step(); reset = 1;
        chk("tp6_req", mem_req, 0);
        chk("tp6_pc", pc, RESET_PC);
        step();
        chk("tp6_restart", mem_addr, RESET_PC);
        wait_valid(k);
        chk("tp6_instr", instruction, 16'h2322);
        lat_lo = 0; lat_hi = 3;
        for (int i = 0; i < 4000; i++) begin
            reset = (reset == 0) ? 1'($urandom_range(1, 0)) : ($urandom_range(299, 0) != 0);
            redirect = reset && !in_rst && ($urandom_range(11, 0) == 0);
            redirect_pc = ($urandom_range(3, 0) == 0) ? 16'hFFFF - 16'($urandom_range(2, 0)) : 16'($urandom);
            instr_next = 1'($urandom_range(1, 0));
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
